// File: rtl/tlb_refill_walker.sv
// -----------------------------------------------------------------------------
// tlb_refill_walker
//   Hardware TLB refill engine. On a TLB miss it walks a two-level page table
//   through a req/ack memory read port, then either writes the translation
//   into the TLB's random-write port (tlbwr/vpn/pte) or pulses a page fault.
//
//   Optional feature macro: TLB_WALK_PERF_EN
//     defined   -> walk_cnt / fault_cnt are saturating event counters
//     undefined -> both counters are tied to 16'h0000
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   clr        in   synchronous active-high reset, highest priority
//   miss       in   level miss flag from the TLB lookup path
//   miss_vpn   in   VPN that missed, stable while miss is high
//   ptbr       in   page-table base byte address (bits [11:0] ignored)
//   mem_req    out  memory read request (registered)
//   mem_addr   out  word-aligned read byte address (registered)
//   mem_ack    in   read done, mem_rdata valid in the same cycle
//   mem_rdata  in   read data; bit 31 = present, [30:24] ignored
//   tlbwr      out  one-cycle TLB write strobe
//   vpn        out  VPN written to the TLB
//   pte        out  PTE written to the TLB
//   busy       out  high whenever the walker is not idle
//   fault      out  one-cycle page-fault pulse
//   fault_lvl  out  0 = level-1 entry absent, 1 = level-2 entry absent
//   walk_cnt   out  completed refills
//   fault_cnt  out  faults taken
// -----------------------------------------------------------------------------
module tlb_refill_walker #(
  parameter int VPN_W = 20,
  parameter int PTE_W = 24
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             miss,
  input  logic [VPN_W-1:0] miss_vpn,
  input  logic [31:0]      ptbr,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             tlbwr,
  output logic [VPN_W-1:0] vpn,
  output logic [PTE_W-1:0] pte,
  output logic             busy,
  output logic             fault,
  output logic             fault_lvl,
  output logic [15:0]      walk_cnt,
  output logic [15:0]      fault_cnt
);

  // The table geometry (10-bit L1 index, 10-bit L2 index, 20-bit frame)
  // assumes VPN_W = 20 and PTE_W <= 24.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_L1       = 3'd1,
    S_L2       = 3'd2,
    S_WRITE    = 3'd3,
    S_FAULT    = 3'd4,
    S_WAIT_CLR = 3'd5
  } state_t;

  state_t state_r;

  // Bits the walker deliberately never looks at.
  logic unused_bits_s;
  assign unused_bits_s = &{1'b0, ptbr[11:0], mem_rdata[30:24]};

  // Walk sequencer: owns the state and every registered output. The L2 table
  // frame is never stored separately; it goes straight into mem_addr.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r   <= S_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      tlbwr     <= 1'b0;
      vpn       <= {VPN_W{1'b0}};
      pte       <= {PTE_W{1'b0}};
      busy      <= 1'b0;
      fault     <= 1'b0;
      fault_lvl <= 1'b0;
    end else begin
      // Strobes default low so they last exactly one cycle.
      tlbwr <= 1'b0;
      fault <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (miss) begin
            vpn      <= miss_vpn;
            mem_req  <= 1'b1;
            mem_addr <= {ptbr[31:12], miss_vpn[19:10], 2'b00};
            busy     <= 1'b1;
            state_r  <= S_L1;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_L1: begin
          if (mem_ack) begin
            if (mem_rdata[31]) begin
              // mem_req stays high; only the address moves to the L2 entry.
              mem_addr <= {mem_rdata[19:0], vpn[9:0], 2'b00};
              state_r  <= S_L2;
            end else begin
              mem_req   <= 1'b0;
              fault     <= 1'b1;
              fault_lvl <= 1'b0;
              state_r   <= S_FAULT;
            end
          end else begin
            state_r <= S_L1;
          end
        end
        S_L2: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_rdata[31]) begin
              pte     <= mem_rdata[PTE_W-1:0];
              tlbwr   <= 1'b1;
              state_r <= S_WRITE;
            end else begin
              fault     <= 1'b1;
              fault_lvl <= 1'b1;
              state_r   <= S_FAULT;
            end
          end else begin
            state_r <= S_L2;
          end
        end
        S_WRITE: begin
          state_r <= S_WAIT_CLR;
        end
        S_FAULT: begin
          state_r <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          // A miss still held from the finished walk must not restart it.
          if (!miss) begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_WAIT_CLR;
          end
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TLB_WALK_PERF_EN
  // Saturating refill and fault counters, stepped once per WRITE / FAULT cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      walk_cnt  <= 16'h0000;
      fault_cnt <= 16'h0000;
    end else begin
      if ((state_r == S_WRITE) && (walk_cnt != 16'hffff)) begin
        walk_cnt <= walk_cnt + 16'h0001;
      end else begin
        walk_cnt <= walk_cnt;
      end
      if ((state_r == S_FAULT) && (fault_cnt != 16'hffff)) begin
        fault_cnt <= fault_cnt + 16'h0001;
      end else begin
        fault_cnt <= fault_cnt;
      end
    end
  end
`else
  assign walk_cnt  = 16'h0000;
  assign fault_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tlb_refill_walker.sv
// -----------------------------------------------------------------------------
// tb_tlb_refill_walker
//   Directed bench for tlb_refill_walker. A transaction-level walk model
//   produces the expected outputs for every cycle; a single negedge process
//   compares them with the DUT. Literal checks pin addresses, PTE, latency,
//   reset behaviour and counters.
// -----------------------------------------------------------------------------
module tb_tlb_refill_walker;

  logic        clk = 1'b0;
  logic        clr, miss, mem_ack;
  logic [19:0] miss_vpn;
  logic [31:0] ptbr, mem_rdata, mem_addr;
  logic        mem_req, tlbwr, busy, fault, fault_lvl;
  logic [19:0] vpn;
  logic [23:0] pte;
  logic [15:0] walk_cnt, fault_cnt;

  always #5 clk = ~clk;

  tlb_refill_walker #(.VPN_W(20), .PTE_W(24)) dut (
    .clk(clk), .clr(clr), .miss(miss), .miss_vpn(miss_vpn), .ptbr(ptbr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .tlbwr(tlbwr), .vpn(vpn), .pte(pte),
    .busy(busy), .fault(fault), .fault_lvl(fault_lvl),
    .walk_cnt(walk_cnt), .fault_cnt(fault_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int miss_c = 0;
  int last_tlb_cyc = -1;

  // expectations for the current cycle
  logic        chk_en = 1'b0;
  logic        e_req, e_tlbwr, e_fault, e_flvl, e_busy;
  logic [31:0] e_addr;
  logic [19:0] e_vpn;
  logic [23:0] e_pte;

  // model state
  logic [19:0] m_vpn = 20'h0;
  logic [23:0] m_pte = 24'h0;
  int n_walks = 0;
  int n_faults = 0;
  logic [31:0] cap_a1, cap_a2;
  logic [23:0] cap_pte;
  logic [19:0] cap_vpn;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int cnt_exp(input int n);
`ifdef TLB_WALK_PERF_EN
    return n;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // single per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req, e_req);
      if (e_req) check("mem_addr", mem_addr, e_addr);
      check("tlbwr", tlbwr, e_tlbwr);
      check("fault", fault, e_fault);
      if (e_fault) check("fault_lvl", fault_lvl, e_flvl);
      check("busy", busy, e_busy);
      check("vpn", vpn, e_vpn);
      check("pte", pte, e_pte);
    end
    if (tlbwr) last_tlb_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input logic req, input logic [31:0] addr, input logic wr,
                          input logic flt, input logic lvl, input logic bsy);
    e_req = req; e_addr = addr; e_tlbwr = wr; e_fault = flt; e_flvl = lvl;
    e_busy = bsy; e_vpn = m_vpn; e_pte = m_pte;
  endtask

  // One complete walk: miss, L1 (w1 waits), L2 (w2 waits), write/fault,
  // h extra cycles of stale miss, then miss drops. Called in an idle cycle.
  task automatic walk(input logic [19:0] v, input logic [31:0] d1, input logic [31:0] d2,
                      input int w1, input int w2, input int h, input logic idle_ack);
    logic [31:0] a1, a2;
    a1 = (ptbr & 32'hFFFF_F000) + (32'(v) / 32'd1024) * 32'd4;
    a2 = (d1 & 32'h000F_FFFF) * 32'd4096 + (32'(v) % 32'd1024) * 32'd4;
    // idle cycle: the miss is presented; an ack here must be ignored
    expect_o(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    miss = 1'b1; miss_vpn = v; mem_ack = idle_ack; mem_rdata = 32'h0000_0000;
    miss_c = cyc;
    last_tlb_cyc = -1;
    step();
    m_vpn = v;
    for (int i = 0; i <= w1; i++) begin
      if (i == 0) cap_a1 = mem_addr;
      expect_o(1'b1, a1, 1'b0, 1'b0, 1'b0, 1'b1);
      mem_ack = (i == w1);
      mem_rdata = (i == w1) ? d1 : $urandom;
      step();
    end
    mem_ack = 1'b0;
    if (!d1[31]) begin
      n_faults++;
      expect_o(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
    end else begin
      for (int i = 0; i <= w2; i++) begin
        if (i == 0) cap_a2 = mem_addr;
        expect_o(1'b1, a2, 1'b0, 1'b0, 1'b0, 1'b1);
        mem_ack = (i == w2);
        mem_rdata = (i == w2) ? d2 : $urandom;
        step();
      end
      mem_ack = 1'b0;
      if (d2[31]) begin
        n_walks++;
        m_pte = d2[23:0];
        cap_pte = pte;
        cap_vpn = vpn;
        expect_o(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
      end else begin
        n_faults++;
        expect_o(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
      end
    end
    for (int i = 0; i <= h; i++) begin
      expect_o(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      miss = (i < h);
      step();
    end
    expect_o(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("walk_cnt", walk_cnt, cnt_exp(n_walks));
    check("fault_cnt", fault_cnt, cnt_exp(n_faults));
  endtask

  initial begin
    clr = 1'b1; miss = 1'b0; miss_vpn = 20'h0; ptbr = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    step(); step();
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_tlbwr", tlbwr, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_vpn", vpn, 20'h0);
    check("rst_pte", pte, 24'h0);
    check("rst_cnt", {walk_cnt, fault_cnt}, 32'h0);
    clr = 1'b0;
    expect_o(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();

    // zero-wait refill, with a spurious ack while idle
    ptbr = 32'h0010_0000;
    walk(20'h80003, 32'h8000_0200, 32'h80ff_0003, 0, 0, 0, 1'b1);
    check("zw_l1_addr", cap_a1, 32'h0010_0800);
    check("zw_l2_addr", cap_a2, 32'h0020_000C);
    check("zw_pte", cap_pte, 24'hff0003);
    check("zw_vpn", cap_vpn, 20'h80003);
    check("zw_latency", last_tlb_cyc - miss_c, 32'd3);

    // two wait cycles per level; ignored bits [30:24] set
    walk(20'h80003, 32'hFF00_0200, 32'hFFff_0003, 2, 2, 0, 1'b0);
    check("ws_latency", last_tlb_cyc - miss_c, 32'd7);

    // level-2 fault, then level-1 fault (fault_lvl must go back to 0)
    walk(20'h80003, 32'h8000_0200, 32'h00ff_0003, 0, 1, 0, 1'b0);
    walk(20'h80003, 32'h0000_0200, 32'h80ff_0003, 1, 0, 0, 1'b0);

    // stale miss held 5 cycles, then a new walk
    walk(20'h80003, 32'h8000_0200, 32'h80ff_0003, 0, 0, 5, 1'b0);
    walk(20'h8000a, 32'h8000_0345, 32'h8012_3456, 0, 0, 0, 1'b0);
    check("new_pte", cap_pte, 24'h123456);

    // reset while in L2, then a late ack
    chk_en = 1'b0;
    miss = 1'b1; miss_vpn = 20'h12345; mem_ack = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h8000_0400;
    step();
    mem_ack = 1'b0;
    check("mid_req", mem_req, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0; miss = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h80ab_cdef;
    check("clr_req", mem_req, 1'b0);
    check("clr_busy", busy, 1'b0);
    check("clr_addr", mem_addr, 32'h0);
    check("clr_vpn", vpn, 20'h0);
    check("clr_pte", pte, 24'h0);
    check("clr_cnt", {walk_cnt, fault_cnt}, 32'h0);
    step();
    mem_ack = 1'b0;
    check("late_ack_wr", tlbwr, 1'b0);
    check("late_ack_busy", busy, 1'b0);
    check("late_ack_pte", pte, 24'h0);
    m_vpn = 20'h0; m_pte = 24'h0; n_walks = 0; n_faults = 0;
    expect_o(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();

    // 8 refills and 2 faults for the counters
    for (int i = 0; i < 10; i++) begin
      logic [31:0] d1, d2;
      ptbr = 32'h0040_0000 + 32'(i) * 32'h0000_1000 + 32'h0000_0ABC;
      d1 = (i == 3) ? 32'h7F00_0010 : (32'h8000_0100 + 32'(i));
      d2 = (i == 7) ? 32'h0000_0077 : (32'h8000_1000 + 32'(i) * 32'h11);
      walk(20'(32'h10000 + 32'(i) * 32'h401), d1, d2, i % 3, (i + 1) % 2, i % 2, 1'b0);
    end
`ifdef TLB_WALK_PERF_EN
    check("walk_cnt_8", walk_cnt, 16'd8);
    check("fault_cnt_2", fault_cnt, 16'd2);
`else
    check("walk_cnt_off", walk_cnt, 16'd0);
    check("fault_cnt_off", fault_cnt, 16'd0);
`endif
    chk_en = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_refill_walker.md
# tlb_refill_walker

Hardware TLB refill engine: the writer side of the 8-entry TLB's random-write port. On a TLB miss it walks a two-level page table in memory over a req/ack read interface. It then drives `tlbwr`, `vpn` and `pte` to refill the TLB, or raises a fault when a table entry is not present. It sits between the TLB lookup path and the memory read port.

## Interface
Parameters:
- `VPN_W`, 20, virtual page number width.
- `PTE_W`, 24, TLB PTE width written to the TLB.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `clr`  in  1  reset. Synchronous and active-high.
- `miss`  in  1  level TLB miss flag from lookup path.
- `miss_vpn`  in  20  VPN that missed; must stay stable while `miss`=1.
- `ptbr`  in  32  page-table base byte address. Bits [11:0] are ignored.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  32  read byte address, word aligned.
- `mem_ack`  in  1  read done. `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.
- `tlbwr`  out  1  one-cycle TLB random-write strobe.
- `vpn`  out  20  VPN written to the TLB.
- `pte`  out  24  PTE written to the TLB.
- `busy`  out  1  high in any state other than IDLE.
- `fault`  out  1  one-cycle page-fault pulse.
- `fault_lvl`  out  1  0 = level-1 entry not present, 1 = level-2 entry not present. Valid with `fault`.
- `walk_cnt`  out  16  completed refills (see Configuration).
- `fault_cnt`  out  16  faults (see Configuration).

## Operation
- States: IDLE, L1, L2, WRITE, FAULT, WAIT_CLR.
- IDLE:
  - `miss`=1 → latch `miss_vpn` into `vpn`, go to L1.
  - `mem_ack` is ignored in IDLE.
- L1:
  - `mem_req`=1, `mem_addr`={ptbr[31:12], vpn[19:10], 2'b00}.
  - On `mem_ack`, if `mem_rdata[31]`=1: latch `mem_rdata[19:0]` as the L2 table frame, go to L2.
  - On `mem_ack`, if `mem_rdata[31]`=0: `fault_lvl`←0, go to FAULT.
- L2:
  - `mem_req`=1, `mem_addr`={frame[19:0], vpn[9:0], 2'b00}.
  - On `mem_ack`, if `mem_rdata[31]`=1: `pte`←`mem_rdata[23:0]`, go to WRITE.
  - On `mem_ack`, if `mem_rdata[31]`=0: `fault_lvl`←1, go to FAULT.
- WRITE: `tlbwr`=1 for exactly this cycle, with `vpn` and `pte` stable. Next state is WAIT_CLR.
- FAULT: `fault`=1 for exactly this cycle. Next state is WAIT_CLR.
- WAIT_CLR: stay until `miss`=0, then go to IDLE. A stale `miss` never triggers a second walk.
- `mem_rdata[30:24]` is ignored at both levels.
- Addresses are formed by bit concatenation only; there is no adder and no carry.

## Timing
- Reset values:
  - `mem_req`, `tlbwr`, `busy`, `fault`, `fault_lvl` = 0.
  - `mem_addr`, `vpn`, `pte` = 0.
  - `walk_cnt`, `fault_cnt` = 0.
  - State = IDLE.
- `clr` has priority over everything, including mid-walk:
  - The next edge forces IDLE and drops `mem_req`.
  - A late `mem_ack` after reset is ignored.
- Memory handshake:
  - `mem_req` and `mem_addr` are registered outputs, held stable until `mem_ack` is sampled high.
  - `mem_req` is 0 in the cycle after the ack edge for L2→WRITE and for any FAULT.
  - Between L1 and L2, `mem_req` stays high and only `mem_addr` changes.
- `mem_ack` may arrive in the first request cycle. Best-case latency:
  - `miss` sampled at edge 0.
  - L1 request in cycle 1, acked.
  - L2 request in cycle 2, acked.
  - `tlbwr` in cycle 3.
- Each wait cycle on `mem_ack` adds one cycle.
- `miss` that rises while `busy`=1 is not queued.
- `busy`=1 from the cycle after the miss is sampled, up to and including the last WAIT_CLR cycle.

## Configuration
- `TLB_WALK_PERF_EN` defined:
  - `walk_cnt` increments on each WRITE cycle.
  - `fault_cnt` increments on each FAULT cycle.
  - Both saturate at 16'hffff and clear on `clr`.
- `TLB_WALK_PERF_EN` undefined: counter logic is absent, and both ports are tied to 16'h0000.

## Test plan
- **Refill, zero-wait:**
  - Stimulus: `ptbr`=32'h00100000, `miss_vpn`=20'h80003, `miss`=1.
  - Required: `mem_addr`=32'h00100800. Respond `mem_ack`=1 with 32'h80000200; then `mem_addr`=32'h0020000C.
  - Respond 32'h80ff0003 → `tlbwr`=1 for one cycle with `vpn`=20'h80003, `pte`=24'hff0003, 3 cycles after the miss.
- **Wait states:** same walk with `mem_ack` delayed 2 cycles at each level → `mem_req`/`mem_addr` held stable; `tlbwr` at cycle 7.
- **Level-1 fault:** L1 data 32'h00000200 → `fault`=1 with `fault_lvl`=0 for one cycle; no `tlbwr`, no L2 request.
- **Level-2 fault:** L2 data 32'h00ff0003 → `fault`=1, `fault_lvl`=1; `tlbwr` stays 0.
- **Stale miss / WAIT_CLR:** hold `miss`=1 for 5 cycles after `tlbwr` → no second `mem_req`. Drop `miss`, re-raise it with 20'h8000a → a new walk starts.
- **Reset mid-walk and counters:**
  - Assert `clr` while in L2 → next cycle all outputs are at reset values; an ack then is ignored.
  - With `TLB_WALK_PERF_EN`: after 8 refills and 2 faults, `walk_cnt`=8 and `fault_cnt`=2.
